// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control : multicycle main control FSM (fetch/decode/exec/mem/wb)
// Rev 1.0 - initial release; optional trap on illegal opcodes (ILLEGAL_OP_TRAP_EN)
// ============================================================================
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               memToReg,
  output logic               regDst,
  output logic               regWrite,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         pcSource,
  output logic [2:0]         aluOP,
  output logic               instrDone,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic               illegalOp,
`endif
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] S_IDLE     = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMADDR  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXEC_R   = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_RWB      = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_EXEC_I   = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_IWB      = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_HALT     = STATE_W'(13);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] next_state;
  logic               op_known;

  assign state = state_q;

  always_comb begin
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: op_known = 1'b1;
      default:                                    op_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_IDLE:    next_state = S_FETCH;
      S_FETCH:   next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                                  next_state = S_EXEC_R;
          OP_LW, OP_SW:                              next_state = S_MEMADDR;
          OP_BEQ:                                    next_state = S_BRANCH;
          OP_J:                                      next_state = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: next_state = S_EXEC_I;
`ifdef ILLEGAL_OP_TRAP_EN
          default:                                   next_state = S_HALT;
`else
          default:                                   next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADDR: next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: next_state = S_MEMWB;
      S_EXEC_R:  next_state = S_RWB;
      S_EXEC_I:  next_state = S_IWB;
`ifdef ILLEGAL_OP_TRAP_EN
      S_HALT:    next_state = S_HALT;
`endif
      default:   next_state = S_FETCH;
    endcase
  end

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    pcSource    = 2'b00;
    aluOP       = 3'b000;
    instrDone   = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    illegalOp   = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        irWrite = 1'b1;
        pcWrite = 1'b1;
        aluSrcB = 2'b01;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
`ifndef ILLEGAL_OP_TRAP_EN
        // Unknown opcodes retire here as a NOP.
        instrDone = ~op_known;
`endif
      end
      S_MEMADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_MEMREAD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      S_MEMWB: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        instrDone = 1'b1;
      end
      S_MEMWRITE: begin
        memWrite  = 1'b1;
        iorD      = 1'b1;
        instrDone = 1'b1;
      end
      S_EXEC_R: begin
        aluSrcA = 1'b1;
        aluOP   = 3'b010;
      end
      S_RWB: begin
        regWrite  = 1'b1;
        regDst    = 1'b1;
        instrDone = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOP       = 3'b001;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        instrDone   = 1'b1;
      end
      S_EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        case (opcode)
          OP_ANDI: aluOP = 3'b011;
          OP_ORI:  aluOP = 3'b100;
          OP_XORI: aluOP = 3'b101;
          OP_SLTI: aluOP = 3'b110;
          default: aluOP = 3'b000;
        endcase
      end
      S_IWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_JUMP: begin
        pcWrite   = 1'b1;
        pcSource  = 2'b10;
        instrDone = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_HALT: illegalOp = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle main control FSM. It decodes the instruction opcode and sequences the datapath through fetch, decode, execute, memory and writeback.
- It is the producing end of the 3-bit aluOP interface consumed by the ALU control decoder.
- It drives every datapath enable and mux select as a Moore function of the state register. aluOP in EXEC_I additionally depends on opcode.
- It sits between the instruction register (opcode source) and the datapath.

Parameters:
- STATE_W, 4, state register width; holds 14 states.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; stable from the end of FETCH until the next FETCH.
- pcWrite  out  1  unconditional PC write.
- pcWriteCond  out  1  PC write qualified by ALU zero (gated in datapath).
- iorD  out  1  memory address select; 0=PC, 1=ALUOut.
- memRead  out  1  memory read strobe.
- memWrite  out  1  memory write strobe.
- irWrite  out  1  IR load.
- memToReg  out  1  writeback select; 1=MDR, 0=ALUOut.
- regDst  out  1  destination register; 1=rd, 0=rt.
- regWrite  out  1  register file write.
- aluSrcA  out  1  ALU A input; 0=PC, 1=rs.
- aluSrcB  out  2  ALU B input; 00=rt, 01=4, 10=signext imm, 11=signext imm<<2.
- pcSource  out  2  PC source; 00=ALU, 01=ALUOut, 10=jump target.
- aluOP  out  3  000 add, 001 sub, 010 R-type (use funct), 011 AND, 100 OR, 101 XOR, 110 SLT.
- instrDone  out  1  one-cycle pulse in the last state of each instruction.
- state  out  4  current state, for debug.

Behaviour:
- Reset: rst_n low forces state to IDLE immediately, asynchronously, including mid-instruction. All outputs are 0 in IDLE.
- IDLE goes to FETCH on the first clk edge with rst_n high.
- State encodings and outputs. Any output not listed for a state is 0.
  - IDLE(0): all outputs 0.
  - FETCH(1): memRead, irWrite, pcWrite=1; iorD=0; aluSrcA=0; aluSrcB=01; aluOP=000; pcSource=00.
  - DECODE(2): aluSrcA=0; aluSrcB=11; aluOP=000 (branch target precompute).
  - MEMADDR(3): aluSrcA=1; aluSrcB=10; aluOP=000.
  - MEMREAD(4): memRead=1; iorD=1.
  - MEMWB(5): regWrite=1; memToReg=1; regDst=0; instrDone=1.
  - MEMWRITE(6): memWrite=1; iorD=1; instrDone=1.
  - EXEC_R(7): aluSrcA=1; aluSrcB=00; aluOP=010.
  - RWB(8): regWrite=1; regDst=1; memToReg=0; instrDone=1.
  - BRANCH(9): aluSrcA=1; aluSrcB=00; aluOP=001; pcWriteCond=1; pcSource=01; instrDone=1.
  - EXEC_I(10): aluSrcA=1; aluSrcB=10; aluOP from opcode: addi 000, andi 011, ori 100, xori 101, slti 110.
  - IWB(11): regWrite=1; regDst=0; memToReg=0; instrDone=1.
  - JUMP(12): pcWrite=1; pcSource=10; instrDone=1.
  - HALT(13): only exists with the optional feature.
- Transitions from DECODE, by opcode:
  - 000000 (R-type) → EXEC_R → RWB → FETCH.
  - 100011 (lw) → MEMADDR → MEMREAD → MEMWB → FETCH.
  - 101011 (sw) → MEMADDR → MEMWRITE → FETCH.
  - 000100 (beq) → BRANCH → FETCH.
  - 000010 (j) → JUMP → FETCH.
  - 001000, 001100, 001101, 001110, 001010 (addi/andi/ori/xori/slti) → EXEC_I → IWB → FETCH.
  - Any other opcode: see Optional Feature.
- MEMADDR selects MEMREAD for lw, MEMWRITE otherwise.
- Latency from FETCH to next FETCH: lw 5, sw/R/I 4, beq/j 3 cycles.
- instrDone pulses for exactly one cycle per instruction and never in IDLE or FETCH.
- Unreachable state codes (14, 15) → FETCH on the next edge; all outputs 0 while in them.
- Outputs are combinational from the state register and opcode only. No output is ever X after reset.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE → HALT.
  - HALT holds all enables at 0 and asserts extra output illegalOp=1.
  - HALT is left only via rst_n.
  - instrDone stays 0 in HALT.
- Undefined:
  - An unknown opcode in DECODE → FETCH, with instrDone=1 in DECODE (treated as a NOP).
  - No illegalOp port exists.

Test Plan:
- rst_n=0 then release: state=0 and all outputs 0 while in reset. First edge → state=1 with memRead=irWrite=pcWrite=1 and aluSrcB=01.
- opcode=100011 (lw): state sequence 1,2,3,4,5,1. memRead=1 and iorD=1 in state 4. regWrite=1, memToReg=1 and instrDone=1 in state 5 only.
- opcode=000000 (R-type): aluOP=010 in EXEC_R; RWB has regDst=1 and regWrite=1. Then opcode=001101 (ori): aluOP=100 in EXEC_I; IWB has regDst=0. Repeat for 001110 (xori) → 101 and 001010 (slti) → 110.
- opcode=000100 (beq): 3-cycle instruction; BRANCH has aluOP=001, pcWriteCond=1, pcSource=01. Then opcode=000010 (j): JUMP has pcWrite=1 and pcSource=10.
- opcode=111111: without the macro, DECODE→FETCH with one instrDone pulse. With ILLEGAL_OP_TRAP_EN, state=13 and illegalOp=1, held for 20 cycles until rst_n.
- Assert rst_n=0 mid-cycle during MEMWRITE: memWrite drops to 0 before the next clk edge and state=0. After release, execution restarts at FETCH.
